// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers. It computes one result bit per
// cycle, using shift-add for MULT/MULTU and restoring division for DIV/DIVU.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               is_div_q;
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;
    logic [WIDTH-1:0]   opnd_q;  // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;   // mult: {partial sum, multiplier}; div: low half dividend->quotient
    logic [WIDTH-1:0]   rem_q;

    logic               req_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        req_signed = ~op[0];
        sa         = req_signed & a[WIDTH-1];
        sb         = req_signed & b[WIDTH-1];
        mag_a      = sa ? -a : a;
        mag_b      = sb ? -b : b;

        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};

        // The partial remainder is W+1 bits wide, but the restored result is always below the divisor.
        div_shift  = {rem_q, acc_q[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, opnd_q};
        div_diff   = WIDTH'(div_shift - {1'b0, opnd_q});

        // The sign flags are zero for unsigned ops, so these fix-ups reduce to pass-through.
        prod_fix   = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = sa_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            dz_q        <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        is_div_q <= op[1];
                        sa_q     <= sa;
                        sb_q     <= sb;
                        dz_q     <= op[1] & (b == '0);
                        opnd_q   <= op[1] ? mag_b : mag_a;
                        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= (op[1] && (b == '0)) ? StFix : StCalc;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                StCalc: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        if (is_div_q) begin
                            rem_q              <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], div_ge};
                        end else begin
                            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastIter) state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        done        <= 1'b1;
                        div_by_zero <= dz_q;
                        if (!dz_q) begin
                            if (is_div_q) begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8: directed vector table, corner-case
// sequences and random operands checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8, mthi, mtlo, cancel;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .cancel(cancel),
        .busy(busy32), .done(done32), .div_by_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .mthi(mthi), .mtlo(mtlo), .cancel(cancel),
        .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    logic [1:0]  ro;
    logic [31:0] rx, ry, m_hi, m_lo, e_hi, e_lo;
    logic        e_dz;
    int          n, dones;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and use native * / % (which truncate toward zero).
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, input logic [31:0] phi,
                                  input logic [31:0] plo, output logic [31:0] ehi,
                                  output logic [31:0] elo, output logic edz);
        logic [63:0] mask, pu;
        longint      sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        sx = longint'({32'd0, x} & mask);
        sy = longint'({32'd0, y} & mask);
        if (!o[0]) begin
            if (x[w-1]) sx = sx - longint'(64'd1 << w);
            if (y[w-1]) sy = sy - longint'(64'd1 << w);
        end
        edz = o[1] && (sy == 0);
        ehi = phi;
        elo = plo;
        if (!o[1]) begin
            pu  = 64'(sx * sy);
            ehi = 32'((pu >> w) & mask);
            elo = 32'(pu & mask);
        end else if (!edz) begin
            q   = sx / sy;
            r   = sx % sy;
            ehi = 32'(64'(r) & mask);
            elo = 32'(64'(q) & mask);
        end
    endfunction

    task automatic do_op(input bit w8, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input string nm);
        int k, bc, lat;
        lat = edz ? 1 : (w8 ? 9 : 33);
        op = o;
        a  = x;
        b  = y;
        if (w8) start8 = 1'b1;
        else start32 = 1'b1;
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        k  = 0;
        bc = 0;
        while (!(w8 ? done8 : done32) && k < 100) begin
            if (w8 ? busy8 : busy32) bc++;
            @(posedge clk); #1;
            k++;
        end
        check({nm, " done"}, 64'(w8 ? done8 : done32), 64'd1);
        check({nm, " latency"}, 64'(k), 64'(lat));
        check({nm, " busy cycles"}, 64'(bc), 64'(lat));
        check({nm, " hi"}, w8 ? {56'd0, hi8} : {32'd0, hi32}, {32'd0, ehi});
        check({nm, " lo"}, w8 ? {56'd0, lo8} : {32'd0, lo32}, {32'd0, elo});
        check({nm, " div_by_zero"}, 64'(w8 ? dz8 : dz32), 64'(edz));
    endtask

    task automatic wait_done32(output int k);
        k = 0;
        while (!done32 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};
        vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};

        rst = 1'b1; start32 = 1'b0; start8 = 1'b0; mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
        op = 2'b00; a = '0; b = '0;
        #12;
        check("reset hi", {32'd0, hi32}, 64'd0);
        check("reset lo", {32'd0, lo32}, 64'd0);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset dz", 64'(dz32), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Random operands at WIDTH=8; the model tracks HI/LO so div-by-zero keeps old values.
        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom_range(0, 255);
            ry = $urandom_range(0, 255);
            if (i % 10 == 0) ry = '0;
            if (i % 10 == 5) begin rx = 32'h80; ry = 32'hFF; end
            model(8, ro, rx, ry, m_hi, m_lo, e_hi, e_lo, e_dz);
            do_op(1'b1, ro, rx, ry, e_hi, e_lo, e_dz, $sformatf("rnd8_%0d", i));
            m_hi = e_hi; m_lo = e_lo;
        end
        do_op(1'b1, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, "w8 div overflow");
        do_op(1'b1, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "w8 mult min");
        do_op(1'b1, 2'b11, 32'h05, 32'h00, 32'h40, 32'h00, 1'b1, "w8 divu zero");

        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 8 == 0) ry = '0;
            if (i % 8 == 4) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            model(32, ro, rx, ry, m_hi, m_lo, e_hi, e_lo, e_dz);
            do_op(1'b0, ro, rx, ry, e_hi, e_lo, e_dz, $sformatf("rnd32_%0d", i));
            m_hi = e_hi; m_lo = e_lo;
        end

        // Directed table, issued back-to-back (each start lands in the previous done cycle).
        for (int i = 0; i < NV; i++)
            do_op(1'b0, vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].ehi, vecs[i].elo, vecs[i].edz,
                  $sformatf("vec%0d", i));

        // MTHI/MTLO while idle, separately and together.
        a = 32'h12345678; mthi = 1'b1; @(posedge clk); #1; mthi = 1'b0;
        a = 32'h9ABCDEF0; mtlo = 1'b1; @(posedge clk); #1; mtlo = 1'b0;
        check("mthi", {32'd0, hi32}, 64'h12345678);
        check("mtlo", {32'd0, lo32}, 64'h9ABCDEF0);
        a = 32'h55AA55AA; mthi = 1'b1; mtlo = 1'b1; @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", {32'd0, hi32}, 64'h55AA55AA);
        check("mthi+mtlo lo", {32'd0, lo32}, 64'h55AA55AA);

        // MTHI ignored alongside start and while busy.
        a = 32'h11111111; mthi = 1'b1; @(posedge clk); #1; mthi = 1'b0;
        op = 2'b01; a = 32'd9; b = 32'd9; start32 = 1'b1; mthi = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; mthi = 1'b0;
        check("mthi with start", {32'd0, hi32}, 64'h11111111);
        repeat (3) begin @(posedge clk); #1; end
        a = 32'hDEADBEEF; mthi = 1'b1; mtlo = 1'b1; @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi busy hi", {32'd0, hi32}, 64'h11111111);
        check("mtlo busy lo", {32'd0, lo32}, 64'h55AA55AA);
        wait_done32(n);
        check("busy op done", 64'(done32), 64'd1);
        check("busy op hi", {32'd0, hi32}, 64'd0);
        check("busy op lo", {32'd0, lo32}, 64'd81);

        // Second start while busy is ignored: exactly one done pulse.
        op = 2'b01; a = 32'd6; b = 32'd7; start32 = 1'b1; @(posedge clk); #1;
        dones = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5 || c == 20) begin start32 = 1'b1; a = 32'd100; b = 32'd100; end
            else start32 = 1'b0;
            @(posedge clk); #1;
            if (done32) dones++;
        end
        start32 = 1'b0;
        check("restart done count", 64'(dones), 64'd1);
        check("restart lo", {32'd0, lo32}, 64'd42);
        check("restart hi", {32'd0, hi32}, 64'd0);

        // Cancel at iteration 10.
        a = 32'hA5A5A5A5; mthi = 1'b1; @(posedge clk); #1; mthi = 1'b0;
        a = 32'h5A5A5A5A; mtlo = 1'b1; @(posedge clk); #1; mtlo = 1'b0;
        op = 2'b01; a = 32'd3; b = 32'd5; start32 = 1'b1; @(posedge clk); #1; start32 = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        cancel = 1'b1; @(posedge clk); #1; cancel = 1'b0;
        check("cancel busy", 64'(busy32), 64'd0);
        dones = int'(done32);
        repeat (50) begin @(posedge clk); #1; if (done32) dones++; end
        check("cancel no done", 64'(dones), 64'd0);
        check("cancel hi", {32'd0, hi32}, 64'hA5A5A5A5);
        check("cancel lo", {32'd0, lo32}, 64'h5A5A5A5A);

        // Cancel while idle does not block a same-cycle start.
        op = 2'b01; a = 32'd2; b = 32'd3; start32 = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; cancel = 1'b0;
        check("idle cancel busy", 64'(busy32), 64'd1);
        wait_done32(n);
        check("idle cancel done", 64'(done32), 64'd1);
        check("idle cancel lo", {32'd0, lo32}, 64'd6);

        // Asynchronous reset in the middle of CALC.
        a = 32'hCAFEF00D; mthi = 1'b1; @(posedge clk); #1; mthi = 1'b0;
        op = 2'b00; a = 32'hFFFFFFF0; b = 32'd3; start32 = 1'b1; @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre-rst busy", 64'(busy32), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("async rst hi", {32'd0, hi32}, 64'd0);
        check("async rst lo", {32'd0, lo32}, 64'd0);
        check("async rst busy", 64'(busy32), 64'd0);
        check("async rst done", 64'(done32), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post rst busy", 64'(busy32), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
